instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage ahead of the main decoder: owns the PC, issues in-order requests to the
//   instruction memory, and buffers returned words in a small FIFO. It hands instr/pc/opcode
//   to decode with a valid/ready handshake. Branch/jump redirects flush everything in flight.
// PARAMETERS
//   XLEN        32        address/data width
//   RESET_PC    32'h0     PC loaded on reset
//   FIFO_DEPTH  2         instruction buffer entries; also max requests outstanding
// PORTS
//   clk            in   1     single clock, rising edge
//   rst            in   1     asynchronous, active-high reset
//   imem_req_valid out  1     fetch request valid
//   imem_req_ready in   1     memory accepts request
//   imem_req_addr  out  XLEN  word address of request
//   imem_rsp_valid in   1     response valid (in order, >=1 cycle after accept)
//   imem_rsp_data  in   32    returned instruction word
//   redirect       in   1     taken branch / jump from pc_src logic
//   redirect_pc    in   XLEN  redirect target
//   out_valid      out  1     instruction available to decode
//   out_ready      in   1     decode consumes instruction
//   out_instr      out  32    instruction word
//   out_pc         out  XLEN  PC of out_instr
//   out_pc_plus4   out  XLEN  out_pc + 4, modulo 2^XLEN
//   out_opcode     out  7     out_instr[6:0], feeds main decoder opcode
//   misaligned     out  1     sticky misaligned-redirect flag (FETCH_ALIGN_CHECK_EN only)
// BEHAVIOUR
//   Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE.
//     All outputs are 0.
//   FSM: IDLE -> RUN after 1 cycle. RUN -> FLUSH on redirect with outstanding>0.
//     FLUSH -> RUN when drop_cnt reaches 0. HALT exists only with the macro.
//   Request: imem_req_valid=1 in RUN/FLUSH when outstanding+fifo_count < FIFO_DEPTH and
//     redirect=0. On accept (valid&ready): outstanding++, fetch_pc += 4 (wraps mod 2^XLEN).
//   imem_req_addr = fetch_pc. Both are held stable while valid&!ready.
//   Response: if drop_cnt>0, the word is discarded and drop_cnt--. Otherwise it is pushed
//     with its PC (per-request PC queue). outstanding-- in both cases.
//     The credit rule guarantees no overflow, so there is no rsp_ready.
//   rsp_valid with outstanding==0 is ignored.
//   Output: registered FIFO head. A response in cycle N gives out_valid in N+1 if the FIFO
//     was empty. Pop on out_valid&out_ready.
//   Redirect: the FIFO is flushed the same edge. fetch_pc <= redirect_pc.
//     drop_cnt <= outstanding after this cycle's accept/response bookkeeping.
//     out_valid=0 the next cycle. A response arriving in the redirect cycle is dropped.
//     Redirect wins over a same-cycle pop and push. A redirect during FLUSH reloads
//     drop_cnt the same way.
//   Simultaneous push+pop with the FIFO full is legal; the count is unchanged.
//   rst asserted mid-operation: immediate return to reset state. Pending responses are
//     not tracked; the memory must be reset with the core.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets misaligned=1 and enters HALT.
//     In HALT, imem_req_valid=0 and out_valid=0 until reset.
//   Not defined: redirect_pc[1:0] is forced to 2'b00; misaligned is tied 0.
// TESTING
//   1 Reset, then release. Memory: 1-cycle latency, always ready.
//     -> all outputs 0 during reset; requests to 0x0, 0x4, 0x8 on consecutive cycles.
//   2 mem[0]=0x00500093, out_ready=1
//     -> out_instr=0x00500093, out_pc=0x0, out_pc_plus4=0x4, out_opcode=0x13.
//   3 out_ready=0 -> at most 2 accepts, then imem_req_valid=0.
//     Raise out_ready -> pc 0x0, 0x4, 0x8 delivered in order with no loss.
//   4 Redirect to 0x100 with 2 in flight -> next 2 responses discarded;
//     next out_pc=0x100, then 0x104.
//   5 rst pulse mid-stream -> outputs 0 asynchronously; fetching restarts at RESET_PC.
//   6 redirect_pc=0x102: with macro -> misaligned=1, no further requests.
//     Without macro -> fetch resumes at 0x100.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-stage bundle carrying the imem request/response, the redirect from pc_src and the decode handoff
//   master: fetch unit side (drives imem_req_*, out_*, misaligned)
//   slave : memory / pc_src / decode side (drives imem_req_ready, imem_rsp_*, redirect*, out_ready)
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [6:0]      out_opcode;
  logic            misaligned;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_opcode, misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_opcode, misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues in-order imem requests under a credit limit, buffers responses and hands instr/pc/opcode to decode
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_fetch_unit_if.master (imem request/response, redirect, decode handoff, misaligned flag)
//   Optional: FETCH_ALIGN_CHECK_EN enables the misaligned-redirect HALT state and sticky misaligned flag.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
`endif
  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0]   outstanding, outstanding_nxt, drop_cnt, count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
  logic [31:0]     instr;
  logic            live, halted, bad_align, redir, req_hold, credit, accept, rsp, push, pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_r;
  assign halted = state == HALT;
  assign bad_align = bus.redirect_pc[1:0] != 2'b00;
  assign bus.misaligned = misaligned_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned_r <= 1'b0;
    else if (redir && bad_align) misaligned_r <= 1'b1;
  end
`else
  assign halted = 1'b0;
  assign bad_align = 1'b0;
  assign bus.misaligned = 1'b0;
`endif
  assign live = state == RUN || state == FLUSH;
  assign redir = bus.redirect && !halted;
  assign target = bus.redirect_pc & ~XLEN'(3);
  assign rsp = bus.imem_rsp_valid && outstanding != '0;
  assign pop = bus.out_valid && bus.out_ready;
  // A slot freed by this cycle's pop is usable: the earliest response to a new request lands next cycle.
  assign credit = int'(outstanding) + int'(count) - int'(pop) < FIFO_DEPTH;
  // req_hold keeps a stalled request asserted even if the pop that granted its credit goes away.
  assign bus.imem_req_valid = live && !redir && (req_hold || credit);
  assign bus.imem_req_addr = fetch_pc;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign push = rsp && drop_cnt == '0 && !redir;
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);
  assign bus.out_valid = count != '0 && !halted;
  assign instr = bus.out_valid ? instr_mem[rd_ptr] : '0;
  assign bus.out_instr = instr;
  assign bus.out_opcode = instr[6:0];
  assign bus.out_pc = bus.out_valid ? pc_mem[rd_ptr] : '0;
  assign bus.out_pc_plus4 = bus.out_valid ? pc_mem[rd_ptr] + XLEN'(4) : '0;
  always_comb begin
    state_nxt = state == IDLE ? RUN :
                state == RUN ? (redir && outstanding != '0 ? FLUSH : RUN) :
                state == FLUSH ? (!redir && drop_cnt == '0 ? RUN : FLUSH) : state;
`ifdef FETCH_ALIGN_CHECK_EN
    if (redir && bad_align) state_nxt = HALT;
`endif
  end
  // rsp_pc is the PC of the next kept response: requests between redirects are consecutive words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_hold <= 1'b0;
    end else begin
      state <= state_nxt;
      outstanding <= outstanding_nxt;
      req_hold <= bus.imem_req_valid && !bus.imem_req_ready;
      if (redir) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop_cnt <= outstanding_nxt;
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wrap_inc(wr_ptr);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= wrap_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr] <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench for instr_fetch_unit with an in-order memory model and a delivered-stream reference
module tb_instr_fetch_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();
  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  logic [31:0] acc_addr[$];
  int acc_cyc[$];
  int checks = 0, errors = 0, cyc = 0, last_due = 0, pops = 0;
  int lat_lo = 1, lat_hi = 1, rdy_pct = 100, ordy_pct = 100, redir_pm = 0;
  logic force_redir = 1'b0, spurious = 1'b0, gap = 1'b0, held = 1'b0;
  logic [31:0] force_pc = '0, exp_pc = '0, held_addr = '0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'h00500093 : (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]};
  endfunction
  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(3) == 0 ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h0000_FFFF);
`ifdef FETCH_ALIGN_CHECK_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    logic [31:0] w, p4;
    int lat;
    bus.imem_req_ready = $urandom_range(99) < rdy_pct;
    bus.out_ready = $urandom_range(99) < ordy_pct;
    if (spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = $urandom;
    end else begin
      bus.imem_rsp_valid = mq.size() != 0 && mq[0].due <= cyc;
      bus.imem_rsp_data = mq.size() != 0 ? word(mq[0].addr) : $urandom;
    end
    bus.redirect = force_redir || ($urandom_range(999) < redir_pm);
    bus.redirect_pc = force_redir ? force_pc : rand_target();
    #1;
    if (gap) chk("gap_out_valid", bus.out_valid, 0);
    if (held && !bus.redirect) begin
      chk("hold_valid", bus.imem_req_valid, 1);
      chk("hold_addr", bus.imem_req_addr, held_addr);
    end
    chk("credit", mq.size() <= DEPTH, 1);
    if (bus.out_valid && bus.out_ready) begin
      w = word(exp_pc);
      p4 = exp_pc + 32'd4;
      chk("out_pc", bus.out_pc, exp_pc);
      chk("out_instr", bus.out_instr, w);
      chk("out_pc_plus4", bus.out_pc_plus4, p4);
      chk("out_opcode", bus.out_opcode, w[6:0]);
      exp_pc = p4;
      pops++;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      lat = cyc + int'($urandom_range(lat_hi, lat_lo));
      last_due = lat > last_due ? lat : last_due;
      mq.push_back('{addr: bus.imem_req_addr, due: last_due});
      acc_addr.push_back(bus.imem_req_addr);
      acc_cyc.push_back(cyc);
    end
    if (bus.imem_rsp_valid && !spurious) void'(mq.pop_front());
    held = bus.imem_req_valid && !bus.imem_req_ready;
    held_addr = bus.imem_req_addr;
    gap = bus.redirect;
    if (bus.redirect) exp_pc = bus.redirect_pc & ~32'h3;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    bus.redirect = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr", bus.imem_req_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_pc_plus4", bus.out_pc_plus4, 0);
    chk("rst_out_opcode", bus.out_opcode, 0);
    chk("rst_misaligned", bus.misaligned, 0);
    mq.delete();
    acc_addr.delete();
    acc_cyc.delete();
    last_due = 0;
    exp_pc = '0;
    gap = 1'b0;
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, n0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (8) cycle();
    chk("t1_accepts", acc_addr.size() >= 3, 1);
    if (acc_addr.size() >= 3) begin
      chk("t1_addr0", acc_addr[0], 32'h0);
      chk("t1_addr1", acc_addr[1], 32'h4);
      chk("t1_addr2", acc_addr[2], 32'h8);
      chk("t1_gap01", acc_cyc[1] - acc_cyc[0], 1);
      chk("t1_gap12", acc_cyc[2] - acc_cyc[1], 1);
    end
    chk("t2_delivered", pops >= 3, 1);
    do_reset();
    ordy_pct = 0;
    repeat (10) cycle();
    chk("t3_accepts", acc_addr.size(), 2);
    chk("t3_req_low", bus.imem_req_valid, 0);
    ordy_pct = 100;
    p0 = pops;
    repeat (10) cycle();
    chk("t3_delivered", pops - p0 >= 3, 1);
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) cycle();
    chk("t4_inflight", mq.size(), 2);
    force_redir = 1'b1;
    force_pc = 32'h100;
    cycle();
    force_redir = 1'b0;
    p0 = pops;
    for (int i = 0; i < 40 && pops - p0 < 2; i++) cycle();
    chk("t4_delivered", pops - p0 >= 2, 1);
    lat_lo = 1;
    lat_hi = 2;
    rdy_pct = 70;
    ordy_pct = 70;
    repeat (7) cycle();
    do_reset();
    spurious = 1'b1;
    cycle();
    spurious = 1'b0;
    lat_hi = 1;
    rdy_pct = 100;
    ordy_pct = 100;
    repeat (10) cycle();
    chk("t5_restart_addr", acc_addr.size() != 0 ? acc_addr[0] : 32'hDEAD_BEEF, 32'h0);
    p0 = pops;
    for (int s = 0; s < 40; s++) begin
      lat_hi = int'($urandom_range(4, 1));
      rdy_pct = int'($urandom_range(100, 30));
      ordy_pct = int'($urandom_range(100, 20));
      redir_pm = int'($urandom_range(60));
      if (s == 20) do_reset();
      repeat (100) cycle();
    end
    chk("rand_delivered", pops - p0 > 200, 1);
    redir_pm = 0;
    lat_hi = 1;
    rdy_pct = 100;
    ordy_pct = 100;
    force_redir = 1'b1;
    force_pc = 32'h102;
    cycle();
    force_redir = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_misaligned", bus.misaligned, 1);
    n0 = acc_addr.size();
    repeat (10) cycle();
    chk("t6_no_requests", acc_addr.size(), n0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_misaligned_sticky", bus.misaligned, 1);
`else
    n0 = acc_addr.size();
    p0 = pops;
    repeat (10) cycle();
    chk("t6_resume_addr", acc_addr.size() > n0 ? acc_addr[n0] : 32'hDEAD_BEEF, 32'h100);
    chk("t6_delivered", pops - p0 >= 3, 1);
    chk("t6_misaligned", bus.misaligned, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
